// File: rtl/firmware_rom_arbiter.sv
// Two-master arbiter for the single-port firmware ROM/RAM: port A (instruction fetch) has fixed
// priority, port B (debug/loader) is guaranteed progress by a starvation counter.
module firmware_rom_arbiter #(
  parameter int ROM_WORDS    = 896,
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  output logic              a_waitrequest,
  output logic [31:0]       a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [3:0]        b_byteenable,
  input  logic [31:0]       b_writedata,
  input  logic              b_debugaccess,
  output logic              b_waitrequest,
  output logic [31:0]       b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] rom_address,
  output logic [3:0]        rom_byteenable,
  output logic              rom_chipselect,
  output logic              rom_write,
  output logic [31:0]       rom_writedata,
  output logic              rom_debugaccess,
  output logic              rom_clken,
  input  logic [31:0]       rom_readdata,
  output logic              oor_error,
  output logic              wr_reject
);

  localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W:0] ROM_LIMIT  = (ADDR_W+1)'(ROM_WORDS);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  owner_e            rd_owner_q, rd_owner_d;
  logic              rd_oor_q, rd_oor_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              clken_q;
  logic              oor_error_q, oor_error_d;
  logic              wr_reject_q, wr_reject_d;
  logic [31:0]       a_hold_q, a_hold_d;
  logic [31:0]       b_hold_q, b_hold_d;

  logic              en;
  logic              a_req, b_req, b_force;
  logic              grant_a, grant_b, b_is_write;
  logic [ADDR_W-1:0] sel_addr;
  logic              in_range;
  logic [31:0]       ret_data;

  // Arbitration: A wins ties unless B has waited STARVE_LIMIT consecutive cycles.
  always_comb begin
    en         = clken_q & ~reset;
    a_req      = en & a_read;
    b_req      = en & (b_read | b_write);
    b_force    = (starve_cnt_q == STARVE_MAX);
    grant_a    = a_req & (~b_req | ~b_force);
    grant_b    = b_req & (~a_req | b_force);
    b_is_write = grant_b & b_write;
    sel_addr   = grant_b ? b_address : a_address;
    in_range   = ({1'b0, sel_addr} < ROM_LIMIT);
  end

  always_comb begin
    a_waitrequest   = ~en | (a_read & ~grant_a);
    b_waitrequest   = ~en | ((b_read | b_write) & ~grant_b);
    rom_address     = sel_addr;
    rom_byteenable  = b_is_write ? b_byteenable : 4'hF;
    rom_chipselect  = (grant_a | grant_b) & in_range & ~(b_is_write & ~b_debugaccess);
    rom_write       = b_is_write & b_debugaccess & in_range;
    rom_writedata   = b_writedata;
    rom_debugaccess = grant_b & b_debugaccess;
    rom_clken       = clken_q;
    oor_error       = oor_error_q;
    wr_reject       = wr_reject_q;
  end

  // Read return is combinational from the ROM's registered output; reset squashes a pending return.
  always_comb begin
    ret_data        = rd_oor_q ? 32'h0 : rom_readdata;
    a_readdatavalid = ~reset & (rd_owner_q == OWN_A);
    b_readdatavalid = ~reset & (rd_owner_q == OWN_B);
    a_readdata      = a_readdatavalid ? ret_data : a_hold_q;
    b_readdata      = b_readdatavalid ? ret_data : b_hold_q;
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (grant_a) begin
      rd_owner_d = OWN_A;
    end else if (grant_b & ~b_write) begin
      rd_owner_d = OWN_B;
    end
    rd_oor_d     = ~in_range;
    oor_error_d  = (grant_a | grant_b) & ~in_range;
    wr_reject_d  = b_is_write & ~b_debugaccess;
    starve_cnt_d = 4'd0;
    if (b_req & ~grant_b) begin
      starve_cnt_d = b_force ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
    a_hold_d = a_readdata;
    b_hold_d = b_readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q   <= OWN_NONE;
      rd_oor_q     <= 1'b0;
      starve_cnt_q <= 4'd0;
      clken_q      <= 1'b0;
      oor_error_q  <= 1'b0;
      wr_reject_q  <= 1'b0;
      a_hold_q     <= 32'h0;
      b_hold_q     <= 32'h0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      rd_oor_q     <= rd_oor_d;
      starve_cnt_q <= starve_cnt_d;
      clken_q      <= 1'b1;
      oor_error_q  <= oor_error_d;
      wr_reject_q  <= wr_reject_d;
      a_hold_q     <= a_hold_d;
      b_hold_q     <= b_hold_d;
    end
  end

endmodule

// File: tb/tb_firmware_rom_arbiter.sv
// Self-checking bench for firmware_rom_arbiter: a behavioural ROM plus a transaction-level
// reference model of arbitration, starvation and read return.
module tb_firmware_rom_arbiter;

  localparam int ROM_WORDS    = 896;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  a_address;
  logic        a_read;
  logic        a_waitrequest;
  logic [31:0] a_readdata;
  logic        a_readdatavalid;
  logic [9:0]  b_address;
  logic        b_read;
  logic        b_write;
  logic [3:0]  b_byteenable;
  logic [31:0] b_writedata;
  logic        b_debugaccess;
  logic        b_waitrequest;
  logic [31:0] b_readdata;
  logic        b_readdatavalid;
  logic [9:0]  rom_address;
  logic [3:0]  rom_byteenable;
  logic        rom_chipselect;
  logic        rom_write;
  logic [31:0] rom_writedata;
  logic        rom_debugaccess;
  logic        rom_clken;
  logic [31:0] rom_readdata;
  logic        oor_error;
  logic        wr_reject;

  int n_vec = 0;
  int n_err = 0;

  firmware_rom_arbiter dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_read(a_read), .a_waitrequest(a_waitrequest),
    .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_read(b_read), .b_write(b_write), .b_byteenable(b_byteenable),
    .b_writedata(b_writedata), .b_debugaccess(b_debugaccess), .b_waitrequest(b_waitrequest),
    .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
    .rom_address(rom_address), .rom_byteenable(rom_byteenable), .rom_chipselect(rom_chipselect),
    .rom_write(rom_write), .rom_writedata(rom_writedata), .rom_debugaccess(rom_debugaccess),
    .rom_clken(rom_clken), .rom_readdata(rom_readdata),
    .oor_error(oor_error), .wr_reject(wr_reject)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    if (i == 5) return 32'h1234_5678;
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Behavioural single-port memory with registered read.
  logic [31:0] rom_mem [0:1023];
  logic [31:0] rom_q;
  logic        rom_load;
  always @(posedge clk) begin
    if (rom_load) begin
      for (int k = 0; k < 1024; k++) rom_mem[k] <= init_val(k);
    end else if (rom_clken && rom_chipselect) begin
      if (rom_write) begin
        for (int l = 0; l < 4; l++)
          if (rom_byteenable[l]) rom_mem[rom_address][8*l +: 8] <= rom_writedata[8*l +: 8];
      end else begin
        rom_q <= rom_mem[rom_address];
      end
    end
  end
  assign rom_readdata = rom_q;

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  int          m_starve;
  int          m_owner;
  logic [31:0] m_data, m_a_hold, m_b_hold;
  bit          m_oor, m_rej;
  // Expectations for the current cycle
  int          e_grant, e_addr;
  bit          e_inr, e_bwr, e_a_wait, e_b_wait, e_cs, e_wr, e_a_rv, e_b_rv;
  logic [31:0] e_a_rd, e_b_rd;

  task automatic model_reset();
    m_starve = 0; m_owner = 0; m_data = 32'h0;
    m_a_hold = 32'h0; m_b_hold = 32'h0; m_oor = 0; m_rej = 0;
  endtask

  task automatic predict();
    bit a_req, b_req;
    a_req = a_read;
    b_req = b_read || b_write;
    if (a_req && b_req) e_grant = (m_starve == STARVE_LIMIT) ? 2 : 1;
    else if (a_req)     e_grant = 1;
    else if (b_req)     e_grant = 2;
    else                e_grant = 0;
    e_addr   = (e_grant == 2) ? int'(b_address) : int'(a_address);
    e_inr    = e_addr < ROM_WORDS;
    e_a_wait = a_req && e_grant != 1;
    e_b_wait = b_req && e_grant != 2;
    e_bwr    = (e_grant == 2) && b_write;
    e_cs     = (e_grant != 0) && e_inr && !(e_bwr && !b_debugaccess);
    e_wr     = e_bwr && b_debugaccess && e_inr;
    e_a_rv   = (m_owner == 1);
    e_b_rv   = (m_owner == 2);
    e_a_rd   = e_a_rv ? m_data : m_a_hold;
    e_b_rd   = e_b_rv ? m_data : m_b_hold;
  endtask

  task automatic commit();
    if (m_owner == 1) m_a_hold = m_data;
    if (m_owner == 2) m_b_hold = m_data;
    m_owner = 0;
    if (e_grant == 1 || (e_grant == 2 && !b_write)) begin
      m_owner = e_grant;
      m_data  = e_inr ? ref_mem[e_addr] : 32'h0;
    end
    if (e_wr)
      for (int l = 0; l < 4; l++)
        if (b_byteenable[l]) ref_mem[e_addr][8*l +: 8] = b_writedata[8*l +: 8];
    m_oor = (e_grant != 0) && !e_inr;
    m_rej = e_bwr && !b_debugaccess;
    if ((b_read || b_write) && e_grant != 2)
      m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
    else
      m_starve = 0;
  endtask

  task automatic advance();
    @(posedge clk);
    predict();
    commit();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    a_read = 0; a_address = '0; b_read = 0; b_write = 0; b_address = '0;
    b_byteenable = '0; b_writedata = '0; b_debugaccess = 0;
  endtask

  task automatic test_reset();
    a_read = 1; a_address = 10'h005; b_read = 1; b_address = 10'h006;
    #1;
    n_vec++; if (a_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset a_waitrequest got %b exp 1", a_waitrequest); end
    n_vec++; if (b_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset b_waitrequest got %b exp 1", b_waitrequest); end
    n_vec++; if (a_readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset a_readdatavalid got %b exp 0", a_readdatavalid); end
    n_vec++; if (b_readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset b_readdatavalid got %b exp 0", b_readdatavalid); end
    n_vec++; if (a_readdata !== 32'h0) begin n_err++; $display("FAIL reset a_readdata got %h exp 0", a_readdata); end
    n_vec++; if (b_readdata !== 32'h0) begin n_err++; $display("FAIL reset b_readdata got %h exp 0", b_readdata); end
    n_vec++; if (rom_chipselect !== 1'b0) begin n_err++; $display("FAIL reset rom_chipselect got %b exp 0", rom_chipselect); end
    n_vec++; if (rom_write !== 1'b0) begin n_err++; $display("FAIL reset rom_write got %b exp 0", rom_write); end
    n_vec++; if (rom_clken !== 1'b0) begin n_err++; $display("FAIL reset rom_clken got %b exp 0", rom_clken); end
    n_vec++; if (oor_error !== 1'b0 || wr_reject !== 1'b0) begin n_err++; $display("FAIL reset pulses got oor=%b rej=%b exp 0/0", oor_error, wr_reject); end
    $display("reset: waitreq a=%b b=%b clken=%b", a_waitrequest, b_waitrequest, rom_clken);
    @(posedge clk); @(negedge clk);
    reset = 0; drive_idle(); model_reset();
    @(posedge clk); @(negedge clk); #1;
    n_vec++; if (rom_clken !== 1'b1) begin n_err++; $display("FAIL post_reset rom_clken got %b exp 1", rom_clken); end
    n_vec++; if (a_waitrequest !== 1'b0 || b_waitrequest !== 1'b0) begin n_err++; $display("FAIL post_reset idle waitreq got a=%b b=%b exp 0/0", a_waitrequest, b_waitrequest); end
  endtask

  task automatic test_single_read();
    a_read = 1; a_address = 10'h005;
    #1;
    n_vec++; if (a_waitrequest !== 1'b0) begin n_err++; $display("FAIL single a_waitrequest got %b exp 0", a_waitrequest); end
    n_vec++; if (rom_chipselect !== 1'b1 || rom_address !== 10'h005 || rom_byteenable !== 4'hF) begin n_err++; $display("FAIL single rom_cmd got cs=%b addr=%h be=%h exp 1/005/f", rom_chipselect, rom_address, rom_byteenable); end
    advance();
    drive_idle(); #1;
    n_vec++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'h1234_5678) begin n_err++; $display("FAIL single a_return got v=%b d=%h exp 1/12345678", a_readdatavalid, a_readdata); end
    n_vec++; if (b_readdatavalid !== 1'b0) begin n_err++; $display("FAIL single b_readdatavalid got %b exp 0", b_readdatavalid); end
    $display("single read: a_readdata=%h valid=%b", a_readdata, a_readdatavalid);
    advance();
  endtask

  task automatic test_starvation();
    bit b_win, prev_b;
    for (int k = 0; k < 11; k++) begin
      a_read = 1; b_read = 1;
      a_address = 10'($urandom_range(0, ROM_WORDS - 1));
      b_address = 10'($urandom_range(0, ROM_WORDS - 1));
      #1; predict();
      b_win = (k % 5 == 4);
      n_vec++; if (a_waitrequest !== b_win || b_waitrequest !== !b_win) begin n_err++; $display("FAIL starve cyc %0d waitreq got a=%b b=%b exp a=%b b=%b", k, a_waitrequest, b_waitrequest, b_win, !b_win); end
      if (k > 0) begin
        prev_b = ((k - 1) % 5 == 4);
        n_vec++; if (a_readdatavalid !== !prev_b || b_readdatavalid !== prev_b) begin n_err++; $display("FAIL starve cyc %0d valid got a=%b b=%b exp a=%b b=%b", k, a_readdatavalid, b_readdatavalid, !prev_b, prev_b); end
        n_vec++; if (a_readdata !== e_a_rd || b_readdata !== e_b_rd) begin n_err++; $display("FAIL starve cyc %0d data got a=%h b=%h exp a=%h b=%h", k, a_readdata, b_readdata, e_a_rd, e_b_rd); end
      end
      $display("starve cyc %0d: winner=%s", k, b_win ? "B" : "A");
      advance();
    end
    drive_idle(); #1; advance();
  endtask

  task automatic test_debug_write();
    logic [31:0] old, exp;
    old = init_val(16);
    exp = {old[31:16], 16'hBEEF};
    b_write = 1; b_address = 10'h010; b_writedata = 32'hDEAD_BEEF; b_byteenable = 4'b0011; b_debugaccess = 1;
    #1;
    n_vec++; if (rom_write !== 1'b1 || rom_chipselect !== 1'b1 || rom_byteenable !== 4'b0011) begin n_err++; $display("FAIL dbgwr rom_cmd got wr=%b cs=%b be=%b exp 1/1/0011", rom_write, rom_chipselect, rom_byteenable); end
    n_vec++; if (b_waitrequest !== 1'b0 || rom_debugaccess !== 1'b1) begin n_err++; $display("FAIL dbgwr b_wait/dbg got %b/%b exp 0/1", b_waitrequest, rom_debugaccess); end
    advance();
    drive_idle(); b_read = 1; b_address = 10'h010; #1;
    n_vec++; if (rom_write !== 1'b0 || b_readdatavalid !== 1'b0) begin n_err++; $display("FAIL dbgwr after_write got wr=%b bvalid=%b exp 0/0", rom_write, b_readdatavalid); end
    advance();
    drive_idle(); #1;
    n_vec++; if (b_readdatavalid !== 1'b1 || b_readdata !== exp) begin n_err++; $display("FAIL dbgwr readback got v=%b d=%h exp 1/%h", b_readdatavalid, b_readdata, exp); end
    n_vec++; if (a_readdatavalid !== 1'b0) begin n_err++; $display("FAIL dbgwr a_readdatavalid got %b exp 0", a_readdatavalid); end
    $display("debug write readback: %h", b_readdata);
    advance();
  endtask

  task automatic test_reject_oor();
    b_write = 1; b_address = 10'h020; b_writedata = 32'hCAFE_F00D; b_byteenable = 4'hF; b_debugaccess = 0;
    #1;
    n_vec++; if (rom_write !== 1'b0 || rom_chipselect !== 1'b0 || b_waitrequest !== 1'b0) begin n_err++; $display("FAIL reject cmd got wr=%b cs=%b bwait=%b exp 0/0/0", rom_write, rom_chipselect, b_waitrequest); end
    advance();
    drive_idle(); a_read = 1; a_address = 10'h380; #1;
    n_vec++; if (wr_reject !== 1'b1 || b_readdatavalid !== 1'b0) begin n_err++; $display("FAIL reject pulse got rej=%b bvalid=%b exp 1/0", wr_reject, b_readdatavalid); end
    n_vec++; if (rom_chipselect !== 1'b0 || a_waitrequest !== 1'b0) begin n_err++; $display("FAIL oor cmd got cs=%b await=%b exp 0/0", rom_chipselect, a_waitrequest); end
    advance();
    drive_idle(); #1;
    n_vec++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'h0) begin n_err++; $display("FAIL oor return got v=%b d=%h exp 1/0", a_readdatavalid, a_readdata); end
    n_vec++; if (oor_error !== 1'b1 || wr_reject !== 1'b0) begin n_err++; $display("FAIL oor pulse got oor=%b rej=%b exp 1/0", oor_error, wr_reject); end
    advance();
    #1;
    n_vec++; if (oor_error !== 1'b0) begin n_err++; $display("FAIL oor pulse_width got %b exp 0", oor_error); end
    $display("reject/oor: done");
  endtask

  task automatic test_reset_mid();
    a_read = 1; a_address = 10'h007; #1;
    n_vec++; if (a_waitrequest !== 1'b0) begin n_err++; $display("FAIL midrst accept got await=%b exp 0", a_waitrequest); end
    advance();
    reset = 1; drive_idle(); #1;
    n_vec++; if (a_readdatavalid !== 1'b0) begin n_err++; $display("FAIL midrst squash got avalid=%b exp 0", a_readdatavalid); end
    n_vec++; if (a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1) begin n_err++; $display("FAIL midrst waitreq got a=%b b=%b exp 1/1", a_waitrequest, b_waitrequest); end
    @(posedge clk); @(negedge clk); #1;
    n_vec++; if (a_readdatavalid !== 1'b0 || a_readdata !== 32'h0) begin n_err++; $display("FAIL midrst held got v=%b d=%h exp 0/0", a_readdatavalid, a_readdata); end
    reset = 0; model_reset();
    @(posedge clk); @(negedge clk);
    a_read = 1; a_address = 10'h009; #1;
    n_vec++; if (a_waitrequest !== 1'b0) begin n_err++; $display("FAIL midrst post accept got await=%b exp 0", a_waitrequest); end
    advance();
    drive_idle(); #1;
    n_vec++; if (a_readdatavalid !== 1'b1 || a_readdata !== init_val(9)) begin n_err++; $display("FAIL midrst post return got v=%b d=%h exp 1/%h", a_readdatavalid, a_readdata, init_val(9)); end
    $display("reset mid-op: post-reset read %h", a_readdata);
    advance();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      a_read = ($urandom_range(0, 9) < 6);
      a_address = 10'($urandom_range(0, 1023));
      r = $urandom_range(0, 3);
      b_read = (r == 1) || (r == 3);
      b_write = (r >= 2);
      b_address = 10'($urandom_range(0, 1023));
      b_byteenable = 4'($urandom_range(0, 15));
      b_writedata = $urandom;
      b_debugaccess = ($urandom_range(0, 3) != 0);
      #1; predict();
      n_vec++; if (a_waitrequest !== e_a_wait) begin n_err++; $display("FAIL rnd %0d a_waitrequest got %b exp %b", i, a_waitrequest, e_a_wait); end
      n_vec++; if (b_waitrequest !== e_b_wait) begin n_err++; $display("FAIL rnd %0d b_waitrequest got %b exp %b", i, b_waitrequest, e_b_wait); end
      n_vec++; if (rom_chipselect !== e_cs || rom_write !== e_wr) begin n_err++; $display("FAIL rnd %0d rom_cs/wr got %b/%b exp %b/%b", i, rom_chipselect, rom_write, e_cs, e_wr); end
      n_vec++; if (a_readdatavalid !== e_a_rv || b_readdatavalid !== e_b_rv) begin n_err++; $display("FAIL rnd %0d valid got a=%b b=%b exp a=%b b=%b", i, a_readdatavalid, b_readdatavalid, e_a_rv, e_b_rv); end
      n_vec++; if (a_readdata !== e_a_rd) begin n_err++; $display("FAIL rnd %0d a_readdata got %h exp %h", i, a_readdata, e_a_rd); end
      n_vec++; if (b_readdata !== e_b_rd) begin n_err++; $display("FAIL rnd %0d b_readdata got %h exp %h", i, b_readdata, e_b_rd); end
      n_vec++; if (oor_error !== m_oor || wr_reject !== m_rej) begin n_err++; $display("FAIL rnd %0d pulses got oor=%b rej=%b exp %b/%b", i, oor_error, wr_reject, m_oor, m_rej); end
      $display("rnd %0d: a_rd=%b b_rd=%b b_wr=%b grant=%0d", i, a_read, b_read, b_write, e_grant);
      advance();
    end
  endtask

  initial begin
    reset = 1; rom_load = 1; drive_idle(); model_reset();
    for (int k = 0; k < 1024; k++) ref_mem[k] = init_val(k);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rom_load = 0;
    test_reset();
    test_single_read();
    test_starvation();
    test_debug_write();
    test_reject_oor();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
